// File: rtl/ifetch_buffer_pkg.sv
// rtl/ifetch_buffer_pkg.sv - shared constants and types for the instruction fetch buffer
package ifetch_buffer_pkg;

  localparam logic [31:0] PC_RESET_ADDR = 32'h1c00_0000;
  localparam int          DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hffff_fffc;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - synchronous FIFO of {pc, inst} pairs with flush
module ifetch_fifo
  import ifetch_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [31:0]                  push_pc,
  input  logic [31:0]                  push_inst,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         head_valid,
  output logic [31:0]                  head_pc,
  output logic [31:0]                  head_inst
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic            push_ok;
  logic            pop_ok;

  assign push_ok = push && (count_q != CW'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= '{pc: push_pc, inst: push_inst};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Head is read straight from storage; stale contents when empty are don't-care.
  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head_pc    = mem[rd_ptr].pc;
  assign head_inst  = mem[rd_ptr].inst;

endmodule

// File: rtl/ifetch_buffer.sv
// rtl/ifetch_buffer.sv - sequential fetch PC generator feeding decode through a credit-limited FIFO
module ifetch_buffer
  import ifetch_buffer_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_ADDR,
  parameter int          DEPTH    = DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect_valid_i,
  input  logic [31:0]                  redirect_pc_i,
  output logic                         ram_en_o,
  output logic [31:0]                  ram_raddr_o,
  input  logic [31:0]                  ram_rdata_i,
  output logic                         inst_valid_o,
  input  logic                         inst_ready_i,
  output logic [31:0]                  inst_pc_o,
  output logic [31:0]                  inst_o,
  output logic [$clog2(DEPTH+1)-1:0]   buf_count_o
);

  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   fetch_pc;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic          pop;
  logic          push;

  assign pop  = inst_valid_o & inst_ready_i;
  assign push = inflight & ~redirect_valid_i;

  // The outstanding RAM read holds a slot so a returning word always fits.
  assign credit_used = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign ram_en_o    = ~rst & ~redirect_valid_i & (credit_used < (CW+1)'(DEPTH));
  assign ram_raddr_o = fetch_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= PC_RESET;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid_i) begin
      fetch_pc <= align_pc(redirect_pc_i);
      inflight <= 1'b0;
    end else begin
      inflight <= ram_en_o;
      if (ram_en_o) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid_i),
    .push       (push),
    .push_pc    (inflight_pc),
    .push_inst  (ram_rdata_i),
    .pop        (pop),
    .count      (count),
    .head_valid (inst_valid_o),
    .head_pc    (inst_pc_o),
    .head_inst  (inst_o)
  );

  assign buf_count_o = count;

endmodule

// File: tb/tb_ifetch_buffer.sv
// tb/tb_ifetch_buffer.sv - directed vector bench for ifetch_buffer
module tb_ifetch_buffer;

  localparam logic [31:0] B = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ram_en;
  logic [31:0] ram_raddr;
  logic [31:0] ram_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_pc;
  logic [31:0] inst;
  logic [2:0]  buf_count;

  int errors = 0;
  int checks = 0;

  ifetch_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .ram_en_o         (ram_en),
    .ram_raddr_o      (ram_raddr),
    .ram_rdata_i      (ram_rdata),
    .inst_valid_o     (inst_valid),
    .inst_ready_i     (inst_ready),
    .inst_pc_o        (inst_pc),
    .inst_o           (inst),
    .buf_count_o      (buf_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return a ^ 32'h5a5a_a5a5;
  endfunction

  always @(posedge clk) begin
    if (ram_en) ram_rdata <= ram_word(ram_raddr);
  end

  typedef struct packed {
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        en;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic redir, input logic [31:0] rpc, input logic ready,
                              input logic en, input logic [31:0] addr, input logic valid,
                              input logic [31:0] pc, input logic [2:0] cnt);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.ready = ready; v.en = en;
    v.addr = addr; v.valid = valid; v.pc = pc; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " ram_en"}, 32'(ram_en), 32'd0);
    chk({tag, " ram_raddr"}, ram_raddr, B);
    chk({tag, " inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, " inst_pc"}, inst_pc, 32'd0);
    chk({tag, " inst"}, inst, 32'd0);
    chk({tag, " buf_count"}, 32'(buf_count), 32'd0);
  endtask

  int issued;
  int popped;
  logic [31:0] resume_addr;
  logic        resume_seen;

  initial begin
    // Streaming, backpressure, redirect with pop+push, double redirect, PC wrap.
    tbl.push_back(mk(0, 0,            1, 1, B,            0, 0,            0));
    tbl.push_back(mk(0, 0,            1, 1, B+32'h4,      0, 0,            0));
    tbl.push_back(mk(0, 0,            1, 1, B+32'h8,      1, B,            1));
    tbl.push_back(mk(0, 0,            0, 1, B+32'hc,      1, B+32'h4,      1));
    tbl.push_back(mk(0, 0,            0, 1, B+32'h10,     1, B+32'h4,      2));
    tbl.push_back(mk(0, 0,            0, 0, B+32'h14,     1, B+32'h4,      3));
    tbl.push_back(mk(0, 0,            0, 0, B+32'h14,     1, B+32'h4,      4));
    tbl.push_back(mk(0, 0,            1, 1, B+32'h14,     1, B+32'h4,      4));
    tbl.push_back(mk(0, 0,            1, 1, B+32'h18,     1, B+32'h8,      3));
    tbl.push_back(mk(1, 32'h1c000103, 1, 0, B+32'h1c,     1, B+32'hc,      3));
    tbl.push_back(mk(0, 0,            1, 1, 32'h1c000100, 0, 0,            0));
    tbl.push_back(mk(0, 0,            0, 1, 32'h1c000104, 0, 0,            0));
    tbl.push_back(mk(0, 0,            0, 1, 32'h1c000108, 1, 32'h1c000100, 1));
    tbl.push_back(mk(1, 32'h1c000200, 0, 0, 32'h1c00010c, 1, 32'h1c000100, 2));
    tbl.push_back(mk(1, 32'h1c000300, 1, 0, 32'h1c000200, 0, 0,            0));
    tbl.push_back(mk(0, 0,            1, 1, 32'h1c000300, 0, 0,            0));
    tbl.push_back(mk(0, 0,            1, 1, 32'h1c000304, 0, 0,            0));
    tbl.push_back(mk(0, 0,            1, 1, 32'h1c000308, 1, 32'h1c000300, 1));
    tbl.push_back(mk(1, 32'hfffffffe, 1, 0, 32'h1c00030c, 1, 32'h1c000304, 1));
    tbl.push_back(mk(0, 0,            1, 1, 32'hfffffffc, 0, 0,            0));
    tbl.push_back(mk(0, 0,            1, 1, 32'h00000000, 0, 0,            0));
    tbl.push_back(mk(0, 0,            1, 1, 32'h00000004, 1, 32'hfffffffc, 1));
    tbl.push_back(mk(0, 0,            1, 1, 32'h00000008, 1, 32'h00000000, 1));

    repeat (3) @(negedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      inst_ready     = tbl[i].ready;
      #1;
      chk($sformatf("row%0d ram_en", i), 32'(ram_en), 32'(tbl[i].en));
      chk($sformatf("row%0d ram_raddr", i), ram_raddr, tbl[i].addr);
      chk($sformatf("row%0d inst_valid", i), 32'(inst_valid), 32'(tbl[i].valid));
      chk($sformatf("row%0d buf_count", i), 32'(buf_count), 32'(tbl[i].cnt));
      if (tbl[i].valid) begin
        chk($sformatf("row%0d inst_pc", i), inst_pc, tbl[i].pc);
        chk($sformatf("row%0d inst", i), inst, ram_word(tbl[i].pc));
      end
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Decode stalled from the first cycle: credit limits issue to DEPTH requests.
    rst = 1'b1;
    inst_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    issued = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (ram_en) begin
        chk($sformatf("stall issue%0d addr", issued), ram_raddr, B + 32'(4 * issued));
        issued++;
      end
      @(negedge clk);
    end
    #1;
    chk("stall issued", 32'(issued), 32'd4);
    chk("stall ram_en", 32'(ram_en), 32'd0);
    chk("stall buf_count", 32'(buf_count), 32'd4);
    @(negedge clk);
    inst_ready = 1'b1;
    popped = 0;
    resume_seen = 1'b0;
    resume_addr = '0;
    for (int c = 0; c < 12 && popped < 4; c++) begin
      #1;
      if (ram_en && !resume_seen) begin
        resume_seen = 1'b1;
        resume_addr = ram_raddr;
      end
      if (inst_valid) begin
        chk($sformatf("drain%0d pc", popped), inst_pc, B + 32'(4 * popped));
        chk($sformatf("drain%0d inst", popped), inst, ram_word(B + 32'(4 * popped)));
        popped++;
      end
      @(negedge clk);
    end
    chk("drain count", 32'(popped), 32'd4);
    chk("resume seen", 32'(resume_seen), 32'd1);
    chk("resume addr", resume_addr, B + 32'h10);

    // Asynchronous reset between edges while the stream is running.
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state("async reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("refetch ram_en", 32'(ram_en), 32'd1);
    chk("refetch addr", ram_raddr, B);
    repeat (2) @(negedge clk);
    #1;
    chk("refetch valid", 32'(inst_valid), 32'd1);
    chk("refetch pc", inst_pc, B);
    chk("refetch inst", inst, ram_word(B));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
